// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, FSM state
// encoding, ALU operation classes and datapath mux select encodings.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_MEM_ADDR = 4'd2,
      ST_MEM_RD   = 4'd3,
      ST_MEM_WB   = 4'd4,
      ST_MEM_WR   = 4'd5,
      ST_R_EXEC   = 4'd6,
      ST_R_WB     = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_JUMP     = 4'd9,
      ST_I_EXEC   = 4'd10,
      ST_I_WB     = 4'd11
   } state_t;

   // ALU operation classes, shared with the ALU controller.
   localparam logic [2:0] ALU_OP_ADD   = 3'b000;
   localparam logic [2:0] ALU_OP_SUB   = 3'b001;
   localparam logic [2:0] ALU_OP_OR    = 3'b010;
   localparam logic [2:0] ALU_OP_RTYPE = 3'b011;

   localparam logic [1:0] SRC_B_RT    = 2'b00;
   localparam logic [1:0] SRC_B_FOUR  = 2'b01;
   localparam logic [1:0] SRC_B_IMM   = 2'b10;
   localparam logic [1:0] SRC_B_SHIFT = 2'b11;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       zero_ext;
      logic [2:0] alu_op;
      logic       illegal;
   } ctrl_word_t;

   function automatic logic is_legal(input logic [5:0] op);
      return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_J) || (op == OP_ADDI) || (op == OP_ORI);
   endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Combinational Moore decode of FSM state (plus opcode in DECODE/I_EXEC)
// into the full datapath control word.
module ctrl_word_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] op,
   output ctrl_word_t cw
);

   always_comb begin
      cw           = '0;
      cw.pc_src    = PC_SRC_ALU;
      cw.alu_src_b = SRC_B_RT;
      cw.alu_op    = ALU_OP_ADD;
      case (state)
         ST_FETCH: begin
            cw.mem_read  = 1'b1;
            cw.ir_write  = 1'b1;
            cw.pc_write  = 1'b1;
            cw.alu_src_b = SRC_B_FOUR;
         end
         ST_DECODE: begin
            cw.alu_src_b = SRC_B_SHIFT;
            cw.illegal   = !is_legal(op);
         end
         ST_MEM_ADDR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRC_B_IMM;
         end
         ST_MEM_RD: begin
            cw.mem_read = 1'b1;
            cw.i_or_d   = 1'b1;
         end
         ST_MEM_WB: begin
            cw.reg_write  = 1'b1;
            cw.mem_to_reg = 1'b1;
         end
         ST_MEM_WR: begin
            cw.mem_write = 1'b1;
            cw.i_or_d    = 1'b1;
         end
         ST_R_EXEC: begin
            cw.alu_src_a = 1'b1;
            cw.alu_op    = ALU_OP_RTYPE;
         end
         ST_R_WB: begin
            cw.reg_write = 1'b1;
            cw.reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            cw.alu_src_a     = 1'b1;
            cw.alu_op        = ALU_OP_SUB;
            cw.pc_write_cond = 1'b1;
            cw.pc_src        = PC_SRC_ALUOUT;
         end
         ST_JUMP: begin
            cw.pc_write = 1'b1;
            cw.pc_src   = PC_SRC_JUMP;
         end
         ST_I_EXEC: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRC_B_IMM;
            // ori is a logical op: zero-extend the immediate.
            if (op == OP_ORI) begin
               cw.alu_op   = ALU_OP_OR;
               cw.zero_ext = 1'b1;
            end
         end
         ST_I_WB: begin
            cw.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: state register,
// next-state logic and retired-instruction counter.
module multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       instr_op_i,
   output logic             pc_write_o,
   output logic             pc_write_cond_o,
   output logic [1:0]       pc_src_o,
   output logic             i_or_d_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             ir_write_o,
   output logic             mem_to_reg_o,
   output logic             reg_dst_o,
   output logic             reg_write_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic             zero_ext_o,
   output logic [2:0]       alu_op_o,
   output logic             illegal_o,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retire_cnt_o
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retire_q;
   logic             retire_now;
   ctrl_word_t       cw, cw_gated;

   always_comb begin
      state_d = ST_FETCH;
      case (state_q)
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            case (instr_op_i)
               OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
               OP_R:             state_d = ST_R_EXEC;
               OP_BEQ:           state_d = ST_BRANCH;
               OP_J:             state_d = ST_JUMP;
               OP_ADDI, OP_ORI:  state_d = ST_I_EXEC;
               default:          state_d = ST_FETCH;
            endcase
         end
         ST_MEM_ADDR: state_d = (instr_op_i == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   state_d = ST_MEM_WB;
         ST_R_EXEC:   state_d = ST_R_WB;
         ST_I_EXEC:   state_d = ST_I_WB;
         default:     state_d = ST_FETCH;
      endcase
   end

   assign retire_now = state_q inside {ST_MEM_WB, ST_MEM_WR, ST_R_WB,
                                       ST_BRANCH, ST_JUMP, ST_I_WB};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_FETCH;
         retire_q <= '0;
      end else begin
         state_q <= state_d;
         if (retire_now) retire_q <= retire_q + CNT_W'(1);
      end
   end

   ctrl_word_decode u_decode (
      .state (state_q),
      .op    (instr_op_i),
      .cw    (cw)
   );

   // Reset must silence the datapath immediately, even though state is FETCH.
   assign cw_gated = rst_i ? cw : '0;

   assign pc_write_o      = cw_gated.pc_write;
   assign pc_write_cond_o = cw_gated.pc_write_cond;
   assign pc_src_o        = cw_gated.pc_src;
   assign i_or_d_o        = cw_gated.i_or_d;
   assign mem_read_o      = cw_gated.mem_read;
   assign mem_write_o     = cw_gated.mem_write;
   assign ir_write_o      = cw_gated.ir_write;
   assign mem_to_reg_o    = cw_gated.mem_to_reg;
   assign reg_dst_o       = cw_gated.reg_dst;
   assign reg_write_o     = cw_gated.reg_write;
   assign alu_src_a_o     = cw_gated.alu_src_a;
   assign alu_src_b_o     = cw_gated.alu_src_b;
   assign zero_ext_o      = cw_gated.zero_ext;
   assign alu_op_o        = cw_gated.alu_op;
   assign illegal_o       = cw_gated.illegal;
   assign state_o         = state_q;
   assign retire_cnt_o    = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction table, random instruction stream
// against a path/control reference model, async reset and counter wrap.
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_src;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       zero_ext;
      logic [2:0] alu_op;
      logic       illegal;
   } ctl_t;

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [19:0] states;   // nibble k = state in cycle k
      int          cycles;
      int          dcnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [5:0]       instr_op = 6'd0;
   logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic             mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext, illegal;
   logic [1:0]       pc_src, alu_src_b;
   logic [2:0]       alu_op;
   logic [3:0]       state;
   logic [CNT_W-1:0] retire_cnt;
   ctl_t             dut_c;

   int total = 0;
   int bad = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst_n), .instr_op_i(instr_op),
      .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .pc_src_o(pc_src),
      .i_or_d_o(i_or_d), .mem_read_o(mem_read), .mem_write_o(mem_write),
      .ir_write_o(ir_write), .mem_to_reg_o(mem_to_reg), .reg_dst_o(reg_dst),
      .reg_write_o(reg_write), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
      .zero_ext_o(zero_ext), .alu_op_o(alu_op), .illegal_o(illegal),
      .state_o(state), .retire_cnt_o(retire_cnt)
   );

   always_comb dut_c = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                        ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                        zero_ext, alu_op, illegal};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic legal(input logic [5:0] op);
      return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                        6'b000010, 6'b001000, 6'b001101};
   endfunction

   // Expected control word for a state number, straight from the output table.
   function automatic ctl_t model_ctl(input int st, input logic [5:0] op);
      ctl_t c = '0;
      case (st)
         0:  begin c.mem_read = 1; c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b01; end
         1:  begin c.alu_src_b = 2'b11; c.illegal = !legal(op); end
         2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
         3:  begin c.mem_read = 1; c.i_or_d = 1; end
         4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
         5:  begin c.mem_write = 1; c.i_or_d = 1; end
         6:  begin c.alu_src_a = 1; c.alu_op = 3'b011; end
         7:  begin c.reg_write = 1; c.reg_dst = 1; end
         8:  begin c.alu_src_a = 1; c.alu_op = 3'b001; c.pc_write_cond = 1; c.pc_src = 2'b01; end
         9:  begin c.pc_write = 1; c.pc_src = 2'b10; end
         10: begin
                c.alu_src_a = 1; c.alu_src_b = 2'b10;
                if (op == 6'b001101) begin c.alu_op = 3'b010; c.zero_ext = 1; end
             end
         11: c.reg_write = 1;
         default: ;
      endcase
      return c;
   endfunction

   // State path an instruction walks, from FETCH until its last state.
   function automatic void model_path(input logic [5:0] op, output int p[$]);
      p = '{0, 1};
      case (op)
         6'b100011:           p = {p, 2, 3, 4};
         6'b101011:           p = {p, 2, 5};
         6'b000000:           p = {p, 6, 7};
         6'b000100:           p = {p, 8};
         6'b000010:           p = {p, 9};
         6'b001000, 6'b001101: p = {p, 10, 11};
         default: ;
      endcase
   endfunction

   // Entry/exit point: #1 after a rising edge, DUT in FETCH.
   task automatic run_model(input logic [5:0] op);
      int p[$];
      model_path(op, p);
      instr_op = op;
      foreach (p[k]) begin
         @(negedge clk);
         chk("rnd_state", 32'(state), 32'(p[k]));
         chk("rnd_ctl", 32'(dut_c), 32'(model_ctl(p[k], op)));
         chk("rnd_cnt", 32'(retire_cnt), 32'(exp_cnt % (1 << CNT_W)));
         @(posedge clk); #1;
      end
      if (legal(op)) exp_cnt++;
      chk("rnd_cnt_after", 32'(retire_cnt), 32'(exp_cnt % (1 << CNT_W)));
   endtask

   vec_t       tab[8];
   logic [5:0] legal_ops[7];

   initial begin
      int n;
      int st_exp;
      logic [5:0] op;

      tab[0] = '{"R",       6'b000000, 20'h07610, 4, 1};
      tab[1] = '{"lw",      6'b100011, 20'h43210, 5, 1};
      tab[2] = '{"sw",      6'b101011, 20'h05210, 4, 1};
      tab[3] = '{"beq",     6'b000100, 20'h00810, 3, 1};
      tab[4] = '{"j",       6'b000010, 20'h00910, 3, 1};
      tab[5] = '{"addi",    6'b001000, 20'h0BA10, 4, 1};
      tab[6] = '{"ori",     6'b001101, 20'h0BA10, 4, 1};
      tab[7] = '{"illegal", 6'b111111, 20'h00010, 2, 0};
      legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                    6'b000010, 6'b001000, 6'b001101};

      // Reset held: every control output silent, state and count zero.
      #3;
      chk("rst_ctl", 32'(dut_c), 32'd0);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_cnt", 32'(retire_cnt), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_hold_ctl", 32'(dut_c), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_fetch_ctl", 32'(dut_c), 32'(model_ctl(0, 6'd0)));
      @(posedge clk); #1;
      rst_n = 1'b0; #1; rst_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b0; #1; rst_n = 1'b1;

      // Table: each instruction's state sequence, latency and count delta.
      foreach (tab[v]) begin
         instr_op = tab[v].op;
         n = 0;
         do begin
            st_exp = int'(tab[v].states[n*4 +: 4]);
            @(negedge clk);
            chk({tab[v].name, "_state"}, 32'(state), 32'(st_exp));
            chk({tab[v].name, "_ctl"}, 32'(dut_c), 32'(model_ctl(st_exp, tab[v].op)));
            @(posedge clk); #1;
            n++;
         end while (state != 4'd0 && n < 8);
         chk({tab[v].name, "_cycles"}, 32'(n), 32'(tab[v].cycles));
         exp_cnt += tab[v].dcnt;
         chk({tab[v].name, "_cnt"}, 32'(retire_cnt), 32'(exp_cnt % (1 << CNT_W)));
      end

      // Random instruction stream, some illegal opcodes mixed in.
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 4) == 0) op = 6'($urandom);
         else op = legal_ops[$urandom_range(0, 6)];
         run_model(op);
      end

      // Async reset in the middle of lw, while in MEM_RD.
      instr_op = 6'b100011;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("mrd_state", 32'(state), 32'd3);
      chk("mrd_i_or_d", 32'(i_or_d), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_ctl", 32'(dut_c), 32'd0);
      chk("async_state", 32'(state), 32'd0);
      chk("async_cnt", 32'(retire_cnt), 32'd0);
      @(posedge clk); #1;
      chk("async_hold_ctl", 32'(dut_c), 32'd0);
      rst_n = 1'b1;
      exp_cnt = 0;
      @(negedge clk);
      chk("post_rst_state", 32'(state), 32'd0);
      chk("post_rst_cnt", 32'(retire_cnt), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b0; #1; rst_n = 1'b1;

      // Counter wrap: retire up to all-ones, then one more.
      for (int i = 0; i < (1 << CNT_W) - 1; i++) run_model(6'b000010);
      chk("cnt_all_ones", 32'(retire_cnt), 32'hF);
      run_model(6'b000100);
      chk("cnt_wrap", 32'(retire_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
